spi_atten_scheduler: RTL and testbench
======================================

// Module: spi_atten_scheduler
// PURPOSE
//  Sequences the SPI attenuator/delay serializer. Two requesters compete for the one serializer:
//  attenuator writes and delay-line writes.
//  A round-robin arbiter grants one command at a time, and the block drives the serializer load
//  interface. It waits for the serializer's chip-select completion pulse, then enforces an
//  inter-command gap. Sits between the ZCU111 control-register bank and the serializer.
// PARAMETERS
//  REG_WIDTH      32    command word width; equals the serializer register width
//  LD_CYCLES      2     cycles ser_ld is held high per command (>=1)
//  GAP_CYCLES     32    idle cycles after each command; must exceed one serializer half-bit (>=21)
//  TIMEOUT_CYCLES 4096  WAIT cycles before a command is abandoned
//  DRAIN_CYCLES   1024  cycles after reset before the first grant (lets an unreset serializer finish)
//  CNT_W          16    width of the shared cycle counter; must hold max(all cycle parameters)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous, active-high reset
//  att_valid    in   1          attenuator command pending
//  att_data     in   REG_WIDTH  attenuator command word
//  att_ready    out  1          attenuator command accepted this cycle
//  del_valid    in   1          delay-line command pending
//  del_data     in   REG_WIDTH  delay-line command word
//  del_ready    out  1          delay-line command accepted this cycle
//  ser_data     out  REG_WIDTH  to serializer Data_Register
//  ser_ld       out  1          to serializer ld
//  ser_sel      out  2          to serializer DelAttSelect: 01 = attenuator, 10 = delay
//  ser_att_cs   in   1          from serializer Att_CS
//  ser_del_cs   in   1          from serializer Del_CS
//  busy         out  1          high in every state except IDLE
//  done         out  1          one-cycle pulse when a command completes
//  timeout_err  out  1          sticky; set on timeout, cleared by rst or clear_err
//  clear_err    in   1          clears timeout_err
// BEHAVIOUR
//  Reset values
//   - ser_data = 0, ser_ld = 0, ser_sel = 00, done = 0, timeout_err = 0.
//   - Round-robin pointer points to the attenuator; state = DRAIN, counter = 0.
//   - Reset mid-command abandons the command silently: no done, no err.
//  States: DRAIN, IDLE, LOAD, WAIT, GAP.
//  DRAIN
//   - Counts to DRAIN_CYCLES-1, then IDLE. busy = 1, no grants.
//  IDLE (grant)
//   - If any valid: the winner's ready = 1 combinationally for exactly this cycle (handshake).
//   - Same cycle, registered for next: ser_data <= winner data; ser_sel <= 01 (att) or 10 (del);
//     ser_ld <= 1; pointer <= other requester; state <= LOAD; counter <= 0.
//   - Both valid: the pointer side wins. Only one valid: it wins regardless of pointer.
//  LOAD
//   - ser_ld stays 1 for LD_CYCLES cycles total, then 0; state <= WAIT; counter <= 0.
//   - ser_data and ser_sel are held stable from grant until the next grant.
//  WAIT
//   - Completion = rising edge of the selected CS: ser_att_cs if ser_sel[0], else ser_del_cs.
//     The rising edge is taken from a 1-cycle delayed copy of that CS.
//   - The non-selected CS is ignored.
//   - On completion: done = 1 for one cycle; state <= GAP.
//   - If counter reaches TIMEOUT_CYCLES-1 without an edge: timeout_err <= 1, no done, state <= GAP.
//  GAP
//   - Counts GAP_CYCLES cycles, then IDLE. No grants, so ready = 0.
//  Error flag
//   - clear_err and a new timeout in the same cycle: the flag ends set (set wins).
//  Counter
//   - Single CNT_W-bit counter; never wraps, because each state exits at its terminal count.
//  Throughput
//   - Back-to-back requests from both sides alternate att, del, att, ...
// STRUCTURE
//  - Shared package spi_ctrl_pkg: state encoding constants, SEL_ATT = 2'b01, SEL_DEL = 2'b10.
//  - One sub-module rr_arb2: 2-way round-robin arbiter.
//    Inputs: req[1:0], advance. Outputs: grant one-hot, registered pointer.
//  - FSM, counter and edge detect stay in this module.
// TESTING
//  - Reset: no grant while either valid is held through cycle DRAIN_CYCLES; first att_ready at DRAIN_CYCLES.
//  - Single att write 32'hA5A5_0003: ser_data = A5A5_0003, ser_sel = 01, ser_ld high 2 cycles;
//    serializer model raises Att_CS -> done pulse 1 cycle later, busy low after GAP.
//  - Both valid, continuously: grants are att, del, att, del.
//    ser_sel = 01, 10, 01, 10; each ready is high for exactly 1 cycle.
//  - Timeout: no CS asserted -> timeout_err = 1 after TIMEOUT_CYCLES in WAIT, no done.
//    clear_err -> 0; next command proceeds normally.
//  - Wrong CS: ser_sel = 10 and only Att_CS pulses -> ignored, times out.
//  - rst asserted during WAIT -> all outputs at reset values next cycle, state DRAIN, no done.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared encodings for the SPI attenuator/delay command sequencer.
// State order is free; only SEL_* values are seen by the serializer.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_GAP
  } state_t;

  localparam logic [1:0] SEL_ATT = 2'b01;
  localparam logic [1:0] SEL_DEL = 2'b10;

endpackage

// File: rtl/spi_atten_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves past the winner on advance.
// Bit 0 is the attenuator, bit 1 the delay line; pointer 0 favours the attenuator.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // Attenuator win hands priority to the delay line and vice versa.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance && (|req)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/spi_atten_scheduler.sv
// Arbitrates attenuator/delay commands onto one SPI serializer: load, wait for CS rise, then gap.
// ready is combinational in IDLE only; requesters hold valid until they see ready.
module spi_atten_scheduler
  import spi_ctrl_pkg::*;
#(
  parameter int REG_WIDTH      = 32,
  parameter int LD_CYCLES      = 2,
  parameter int GAP_CYCLES     = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DRAIN_CYCLES   = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 att_valid,
  input  logic [REG_WIDTH-1:0] att_data,
  output logic                 att_ready,
  input  logic                 del_valid,
  input  logic [REG_WIDTH-1:0] del_data,
  output logic                 del_ready,
  output logic [REG_WIDTH-1:0] ser_data,
  output logic                 ser_ld,
  output logic [1:0]           ser_sel,
  input  logic                 ser_att_cs,
  input  logic                 ser_del_cs,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  input  logic                 clear_err
);

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LAST    = CNT_W'(LD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             arb_ptr_unused;
  logic             grant_en;
  logic             cs_sel;
  logic             cs_q;
  logic             cs_rise;

  assign grant_en = (state == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({del_valid, att_valid}),
    .advance (grant_en),
    .grant   (grant),
    .ptr     (arb_ptr_unused)
  );

  assign att_ready = grant_en & grant[0];
  assign del_ready = grant_en & grant[1];
  assign busy      = (state != ST_IDLE);

  // Only the CS of the serializer channel we loaded can complete the command.
  assign cs_sel  = ser_sel[0] ? ser_att_cs : ser_del_cs;
  assign cs_rise = cs_sel & ~cs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_DRAIN;
      cnt         <= '0;
      ser_data    <= '0;
      ser_ld      <= 1'b0;
      ser_sel     <= 2'b00;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cs_q        <= 1'b0;
    end else begin
      done <= 1'b0;
      cs_q <= cs_sel;
      if (clear_err) begin
        timeout_err <= 1'b0;
      end

      unique case (state)
        ST_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_IDLE: begin
          if (|grant) begin
            ser_data <= grant[0] ? att_data : del_data;
            ser_sel  <= grant[0] ? SEL_ATT : SEL_DEL;
            ser_ld   <= 1'b1;
            state    <= ST_LOAD;
            cnt      <= '0;
          end
        end

        ST_LOAD: begin
          if (cnt == LD_LAST) begin
            ser_ld <= 1'b0;
            state  <= ST_WAIT;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_WAIT: begin
          // A CS edge on the final count still counts as completion.
          if (cs_rise) begin
            done  <= 1'b1;
            state <= ST_GAP;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_GAP;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= ST_DRAIN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_atten_scheduler.sv
// Transaction-level bench: each command is played out against timing rules derived from the
// parameters (drain, load length, CS-edge completion, timeout, gap) and a last-winner round-robin model.
module tb_spi_atten_scheduler;

  localparam int RW  = 32;
  localparam int LD  = 2;
  localparam int GAP = 32;
  localparam int TO  = 4096;
  localparam int DR  = 1024;
  localparam int CLK = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          att_valid, del_valid;
  logic [RW-1:0] att_data, del_data;
  logic          att_ready, del_ready;
  logic [RW-1:0] ser_data;
  logic          ser_ld;
  logic [1:0]    ser_sel;
  logic          ser_att_cs, ser_del_cs;
  logic          busy, done, timeout_err;
  logic          clear_err;

  int total = 0;
  int bad   = 0;

  // Model state
  int            cyc;
  int            next_elig;
  int            cs_off = -1;
  bit            last_att;
  bit            exp_err;
  logic [1:0]    exp_sel;
  logic [RW-1:0] exp_data;

  always #(CLK/2) clk = ~clk;

  spi_atten_scheduler #(
    .REG_WIDTH(RW), .LD_CYCLES(LD), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO), .DRAIN_CYCLES(DR), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .att_valid(att_valid), .att_data(att_data), .att_ready(att_ready),
    .del_valid(del_valid), .del_data(del_data), .del_ready(del_ready),
    .ser_data(ser_data), .ser_ld(ser_ld), .ser_sel(ser_sel),
    .ser_att_cs(ser_att_cs), .ser_del_cs(ser_del_cs),
    .busy(busy), .done(done), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Advance to just after the next rising edge; one-cycle pulses are retired here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (clear_err) exp_err = 1'b0;
    clear_err = 1'b0;
    if (cyc == cs_off) begin
      ser_att_cs = 1'b0;
      ser_del_cs = 1'b0;
    end
  endtask

  // A cycle in which no grant may happen.
  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_rdy",  {att_ready, del_ready}, 2'b00);
    chk("idle_busy", busy, (cyc < next_elig));
    chk("idle_done", done, 1'b0);
    chk("idle_ld",   ser_ld, 1'b0);
    chk("idle_sel",  ser_sel, exp_sel);
    chk("idle_data", ser_data, exp_data);
    chk("idle_err",  timeout_err, exp_err);
    tick();
  endtask

  task automatic raise_cs(input bit correct);
    if ((exp_sel == 2'b01) == correct) ser_att_cs = 1'b1;
    else                               ser_del_cs = 1'b1;
    cs_off = cyc + 2;
  endtask

  // mode: 0 = correct CS after d WAIT cycles, 1 = wrong CS only, 2 = no CS, 3 = reset during WAIT
  task automatic run_cmd(input bit va, input bit vd, input int k, input int mode, input int d,
                         input bit keep, input bit clr, input bit setwin,
                         input logic [RW-1:0] ad, input logic [RW-1:0] dd);
    int  e, raise_at, gcyc, w0, endc;
    bit  driven, win_att;
    e        = next_elig;
    raise_at = e + k;
    gcyc     = (raise_at > e) ? raise_at : e;
    driven   = 1'b0;
    if (k > 0) begin
      att_valid = 1'b0;
      del_valid = 1'b0;
    end
    if (clr) clear_err = 1'b1;
    while (cyc < gcyc) begin
      if (!driven && cyc >= raise_at) begin
        if (va && !att_valid) att_data = ad;
        if (vd && !del_valid) del_data = dd;
        att_valid = va;
        del_valid = vd;
        driven    = 1'b1;
      end
      idle_cycle();
    end
    if (!driven) begin
      if (va && !att_valid) att_data = ad;
      if (vd && !del_valid) del_data = dd;
      att_valid = va;
      del_valid = vd;
    end

    // Grant cycle
    win_att = (va && vd) ? !last_att : va;
    @(negedge clk);
    chk("grant", {att_ready, del_ready}, win_att ? 2'b10 : 2'b01);
    chk("grant_busy", busy, 1'b0);
    exp_data = win_att ? att_data : del_data;
    exp_sel  = win_att ? 2'b01 : 2'b10;
    last_att = win_att;
    tick();
    if (keep) begin
      if (win_att) att_data = $urandom;
      else         del_data = $urandom;
    end else begin
      att_valid = 1'b0;
      del_valid = 1'b0;
    end

    for (int i = 0; i < LD; i++) begin
      @(negedge clk);
      chk("load_ld",   ser_ld, 1'b1);
      chk("load_sel",  ser_sel, exp_sel);
      chk("load_data", ser_data, exp_data);
      chk("load_rdy",  {att_ready, del_ready}, 2'b00);
      tick();
    end

    w0   = cyc;
    endc = (mode == 1 || mode == 2) ? w0 + TO : w0 + d + 1;
    while (cyc < endc) begin
      if (cyc == w0 + d) begin
        if (mode == 0 || mode == 3) raise_cs(1'b1);
        if (mode == 1)              raise_cs(1'b0);
        if (mode == 3)              rst = 1'b1;
      end
      if ((mode == 1 || mode == 2) && setwin && cyc == w0 + TO - 1) clear_err = 1'b1;
      @(negedge clk);
      chk("wait_done", done, 1'b0);
      chk("wait_ld",   ser_ld, 1'b0);
      chk("wait_busy", busy, 1'b1);
      chk("wait_rdy",  {att_ready, del_ready}, 2'b00);
      tick();
    end

    if (mode == 3) begin
      rst       = 1'b0;
      exp_err   = 1'b0;
      exp_sel   = 2'b00;
      exp_data  = '0;
      last_att  = 1'b0;
      next_elig = cyc + DR;
      @(negedge clk);
      chk("rst_data", ser_data, '0);
      chk("rst_ld",   ser_ld, 1'b0);
      chk("rst_sel",  ser_sel, 2'b00);
      chk("rst_done", done, 1'b0);
      chk("rst_err",  timeout_err, 1'b0);
      chk("rst_busy", busy, 1'b1);
      tick();
      return;
    end

    @(negedge clk);
    if (mode == 0) begin
      chk("done", done, 1'b1);
      chk("done_err", timeout_err, exp_err);
    end else begin
      chk("to_done", done, 1'b0);
      chk("to_err", timeout_err, 1'b1);
      exp_err = 1'b1;
    end
    chk("end_busy", busy, 1'b1);
    next_elig = endc + GAP;
    tick();
  endtask

  initial begin
    #(CLK * 150000);
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int r, m, mode, k;
    rst        = 1'b1;
    att_valid  = 1'b0;
    del_valid  = 1'b0;
    att_data   = '0;
    del_data   = '0;
    ser_att_cs = 1'b0;
    ser_del_cs = 1'b0;
    clear_err  = 1'b0;
    cyc        = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_data", ser_data, '0);
    chk("reset_ld",   ser_ld, 1'b0);
    chk("reset_sel",  ser_sel, 2'b00);
    chk("reset_done", done, 1'b0);
    chk("reset_err",  timeout_err, 1'b0);
    chk("reset_busy", busy, 1'b1);
    chk("reset_rdy",  {att_ready, del_ready}, 2'b00);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cyc       = 0;
    next_elig = DR;
    last_att  = 1'b0;
    exp_err   = 1'b0;
    exp_sel   = 2'b00;
    exp_data  = '0;

    // Both requesters held through drain; attenuator has initial priority.
    run_cmd(1, 1, -DR, 0, 4, 0, 0, 0, 32'hA5A5_0003, $urandom);
    // Continuous requests from both sides alternate.
    for (int i = 0; i < 4; i++)
      run_cmd(1, 1, -2, 0, $urandom_range(0, 10), 1, 0, 0, $urandom, $urandom);
    // Timeout, then clear and a normal command.
    run_cmd(1, 0, 1, 2, 0, 0, 0, 0, $urandom, $urandom);
    run_cmd(0, 1, 0, 0, 2, 0, 1, 0, $urandom, $urandom);
    // Delay command sees only the attenuator CS.
    run_cmd(0, 1, 0, 1, 3, 0, 0, 0, $urandom, $urandom);
    // Clear in the timeout cycle loses to the new error.
    run_cmd(1, 0, 0, 2, 0, 0, 0, 1, $urandom, $urandom);
    // CS edge on the last WAIT cycle completes the command.
    run_cmd(1, 1, 0, 0, TO - 1, 0, 1, 0, $urandom, $urandom);

    for (int i = 0; i < 120; i++) begin
      r    = $urandom_range(1, 3);
      m    = $urandom_range(0, 39);
      mode = (m == 0) ? 2 : ((m == 1) ? 1 : 0);
      k    = int'($urandom_range(0, 6)) - 3;
      run_cmd(r[0], r[1], k, mode, $urandom_range(0, 20), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    // Reset in WAIT abandons the command, then operation resumes after drain.
    run_cmd(1, 0, 1, 3, 5, 0, 0, 0, $urandom, $urandom);
    run_cmd(1, 1, -DR, 0, 6, 0, 0, 0, $urandom, $urandom);

    att_valid = 1'b0;
    del_valid = 1'b0;
    while (cyc < next_elig + 3) idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
